detect_arbiter: RTL

- Collects threshold-detection events from N_CH per-microphone Threshold channels.
- Round-robin arbitrates between pending channels and returns the single-cycle ack each channel needs to re-arm.
- Forwards each (channel, detect_time) pair downstream over a valid/ready handshake.
- Groups events into "rounds" (one acoustic event heard across the array) and flags round completion or timeout. Sits between the Threshold bank and the time-difference/readout logic.

---
 rtl/detect_arbiter_if.sv | 27 ++
 rtl/detect_arbiter.sv | 83 ++++++++
 2 files changed

// File: rtl/detect_arbiter_if.sv
// detect_arbiter_if: bundle between the Threshold bank, the arbiter and the readout side.
interface detect_arbiter_if #(
  parameter int N_CH = 4,
  parameter int TW   = 32,
  parameter int CH_W = 2
);
  logic [N_CH-1:0]    ch_valid;
  logic [TW*N_CH-1:0] ch_time;
  logic [N_CH-1:0]    ch_ack;
  logic [31:0]        timeout_cycles;
  logic               out_valid;
  logic               out_ready;
  logic [TW-1:0]      out_time;
  logic [CH_W-1:0]    out_ch;
  logic               out_dup;
  logic [N_CH-1:0]    round_mask;
  logic               round_done;
  logic               round_timeout;
  modport slave (
    input  ch_valid, ch_time, timeout_cycles, out_ready,
    output ch_ack, out_valid, out_time, out_ch, out_dup, round_mask, round_done, round_timeout
  );
  modport master (
    output ch_valid, ch_time, timeout_cycles, out_ready,
    input  ch_ack, out_valid, out_time, out_ch, out_dup, round_mask, round_done, round_timeout
  );
endinterface

// File: rtl/detect_arbiter.sv
// detect_arbiter: round-robin collection of Threshold detections, forwarded downstream with round tracking.
module detect_arbiter #(
  parameter int N_CH = 4,
  parameter int TW   = 32,
  parameter int CH_W = 2
) (
  input logic clk,
  input logic rst,
  detect_arbiter_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACK  = 2'd1;
  localparam logic [1:0] SEND = 2'd2;
  logic [1:0]      state_q, state_d;
  logic [CH_W-1:0] rr_q, rr_d, ch_q, ch_d, gnt, idx;
  logic [TW-1:0]   time_q, time_d;
  logic            dup_q, dup_d, done_q, done_d, to_q, to_d;
  logic [N_CH-1:0] mask_q, mask_d, upd;
  logic [31:0]     cnt_q, cnt_d;
  logic            hit, grant, xfer, full, to_hit;
  always_comb begin
    gnt = '0;
    hit = 1'b0;
    idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      idx = CH_W'((int'(rr_q) + i) % N_CH);
      if (bus.ch_valid[idx]) begin
        hit = 1'b1;
        gnt = idx;
      end
    end
  end
  // A timeout and a completing transfer on the same edge report as completion.
  always_comb begin
    grant   = state_q == IDLE && hit;
    xfer    = state_q == SEND && bus.out_ready;
    state_d = grant ? ACK : state_q == ACK ? SEND : xfer ? IDLE : state_q;
    rr_d    = grant ? CH_W'((int'(gnt) + 1) % N_CH) : rr_q;
    ch_d    = grant ? gnt : ch_q;
    time_d  = grant ? bus.ch_time[TW*int'(gnt) +: TW] : time_q;
    dup_d   = grant ? mask_q[gnt] : dup_q;
    upd     = mask_q | (xfer ? N_CH'(1) << ch_q : '0);
    full    = &upd;
    to_hit  = bus.timeout_cycles != '0 && mask_q != '0 && cnt_q == bus.timeout_cycles;
    done_d  = full || to_hit;
    to_d    = to_hit && !full;
    mask_d  = done_d ? '0 : upd;
    cnt_d   = done_d ? '0 :
              (xfer && mask_q == '0) ? 32'd1 :
              mask_q != '0 ? (&cnt_q ? cnt_q : cnt_q + 32'd1) : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= '0;
      ch_q    <= '0;
      time_q  <= '0;
      dup_q   <= 1'b0;
      mask_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      ch_q    <= ch_d;
      time_q  <= time_d;
      dup_q   <= dup_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      to_q    <= to_d;
    end
  end
  assign bus.ch_ack        = state_q == ACK ? N_CH'(1) << ch_q : '0;
  assign bus.out_valid     = state_q == SEND;
  assign bus.out_time      = time_q;
  assign bus.out_ch        = ch_q;
  assign bus.out_dup       = dup_q;
  assign bus.round_mask    = mask_q;
  assign bus.round_done    = done_q;
  assign bus.round_timeout = to_q;
endmodule
